// File: rtl/spi_shift_engine.sv
// SPI shift engine: pops TX FIFO words, shifts them MSB-first on mosi,
// samples miso and pushes the received words into the RX FIFO.
module spi_shift_engine #(
  parameter int M   = 32,
  parameter int NCS = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [4:0]     word_len,
  input  logic           cpol,
  input  logic           cpha,
  input  logic           cs_auto,
  input  logic [1:0]     cs_sel,
  input  logic [NCS-1:0] cs_manual_n,
  input  logic           half_tick,
  input  logic           tx_empty,
  input  logic [M-1:0]   tx_data,
  output logic           tx_pop,
  input  logic           rx_full,
  output logic [M-1:0]   rx_data,
  output logic           rx_push,
  output logic           rx_ovf,
  output logic           sclk,
  output logic           mosi,
  input  logic           miso,
  output logic [NCS-1:0] cs_n,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           pha_q, pha_d;
  logic           lead_q, lead_d;
  logic [M-1:0]   tx_sh_q, tx_sh_d;
  logic [M-1:0]   rx_sh_q, rx_sh_d;
  logic [M-1:0]   rx_data_d;
  logic           tx_pop_d, rx_push_d, rx_ovf_d;
  logic           sclk_d, mosi_d, busy_d;
  logic [NCS-1:0] cs_n_d;
  logic           load;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pha_d     = pha_q;
    lead_d    = lead_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data;
    sclk_d    = sclk;
    mosi_d    = mosi;
    tx_pop_d  = 1'b0;
    rx_push_d = 1'b0;
    rx_ovf_d  = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        load   = enable && !tx_empty;
      end
      SETUP: begin
        if (half_tick) begin
          state_d = SHIFT;
          lead_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (half_tick) begin
          sclk_d = ~sclk;
          lead_d = ~lead_q;
          if (lead_q) begin
            if (!pha_q) rx_sh_d = {rx_sh_q[M-2:0], miso};
            else        mosi_d  = tx_sh_q[cnt_q];
          end else begin
            if (pha_q) rx_sh_d = {rx_sh_q[M-2:0], miso};
            if (cnt_q != 5'd0) begin
              cnt_d = cnt_q - 5'd1;
              if (!pha_q) mosi_d = tx_sh_q[cnt_q-5'd1];
            end else begin
              state_d = HOLD;
              if (rx_full) begin
                rx_ovf_d = 1'b1;
              end else begin
                rx_push_d = 1'b1;
                rx_data_d = rx_sh_d;
              end
            end
          end
        end
      end
      HOLD: begin
        if (half_tick) begin
          if (enable && !tx_empty) load = 1'b1;
          else                     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Word reload, shared by IDLE start and back-to-back HOLD
    if (load) begin
      tx_pop_d = 1'b1;
      tx_sh_d  = tx_data;
      mosi_d   = tx_data[word_len];
      cnt_d    = word_len;
      pha_d    = cpha;
      rx_sh_d  = '0;
      state_d  = SETUP;
    end

    if (!enable) begin
      state_d   = IDLE;
      sclk_d    = cpol;
      rx_push_d = 1'b0;
      rx_ovf_d  = 1'b0;
      rx_data_d = rx_data;
    end

    busy_d = (state_d != IDLE);
    if (!cs_auto)
      cs_n_d = cs_manual_n;
    else if (state_d == IDLE)
      cs_n_d = '1;
    else
      cs_n_d = ~(NCS'(1) << cs_sel);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pha_q   <= 1'b0;
      lead_q  <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_data <= '0;
      tx_pop  <= 1'b0;
      rx_push <= 1'b0;
      rx_ovf  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pha_q   <= pha_d;
      lead_q  <= lead_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_data <= rx_data_d;
      tx_pop  <= tx_pop_d;
      rx_push <= rx_push_d;
      rx_ovf  <= rx_ovf_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      cs_n    <= cs_n_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: vector table plus
// back-to-back, overflow, abort and async-reset sequences.
module tb_spi_shift_engine;

  logic        clk, reset, enable;
  logic [4:0]  word_len;
  logic        cpol, cpha, cs_auto;
  logic [1:0]  cs_sel;
  logic [3:0]  cs_manual_n;
  logic        half_tick, tx_empty;
  logic [31:0] tx_data;
  logic        tx_pop, rx_full;
  logic [31:0] rx_data;
  logic        rx_push, rx_ovf;
  logic        sclk, mosi, miso;
  logic [3:0]  cs_n;
  logic        busy;
  logic        miso_inv;

  assign miso = mosi ^ miso_inv;

  spi_shift_engine #(.M(32), .NCS(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .word_len(word_len), .cpol(cpol), .cpha(cpha),
    .cs_auto(cs_auto), .cs_sel(cs_sel),
    .cs_manual_n(cs_manual_n), .half_tick(half_tick),
    .tx_empty(tx_empty), .tx_data(tx_data),
    .tx_pop(tx_pop), .rx_full(rx_full),
    .rx_data(rx_data), .rx_push(rx_push),
    .rx_ovf(rx_ovf), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int hc;
    hc = 0;
    half_tick = 1'b0;
    forever begin
      @(negedge clk);
      hc = (hc == 2) ? 0 : hc + 1;
      half_tick = (hc == 0);
    end
  end

  // Passive monitor, sampled on the falling edge
  int          tog_cnt = 0, wtog = 0;
  int          pop_cnt = 0, push_cnt = 0, ovf_cnt = 0;
  int          long_cnt = 0, cs_bad = 0, busy_fall = 0;
  logic [63:0] mosi_word = '0;
  logic [31:0] rx_log [4];
  logic        sclk_q = 0, busy_q = 0;
  logic        pop_q = 0, push_q = 0, ovf_q = 0;
  logic [3:0]  exp_cs = 4'hF;

  always @(negedge clk) begin
    if (busy && sclk != sclk_q) begin
      tog_cnt++;
      wtog++;
      if (cpha ? (wtog % 2 == 0) : (wtog % 2 == 1))
        mosi_word = {mosi_word[62:0], mosi};
    end
    if (!busy) wtog = 0;
    if (tx_pop) pop_cnt++;
    if (rx_push) begin
      rx_log[push_cnt % 4] = rx_data;
      push_cnt++;
    end
    if (rx_ovf) ovf_cnt++;
    if ((tx_pop && pop_q) || (rx_push && push_q) || (rx_ovf && ovf_q))
      long_cnt++;
    if (busy && cs_n != exp_cs) cs_bad++;
    if (busy_q && !busy) busy_fall++;
    sclk_q = sclk;
    busy_q = busy;
    pop_q  = tx_pop;
    push_q = rx_push;
    ovf_q  = rx_ovf;
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int n, input logic [31:0] w0,
                     input logic [31:0] w1);
    int  idx;
    bit  done;
    idx = 0;
    done = 0;
    tx_data = w0;
    tx_empty = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (tx_pop) begin
        idx++;
        if (idx < n) tx_data = w1;
        else         tx_empty = 1'b1;
      end
      if (idx >= n && !busy) done = 1;
    end
    tx_empty = 1'b1;
    #1;
    chk("done", 64'(done), 64'd1);
  endtask

  typedef struct {
    logic        cpol, cpha, auto_cs, inv;
    logic [1:0]  sel;
    logic [3:0]  man;
    logic [4:0]  wl;
    logic [31:0] data, exp_rx, exp_mosi;
    int          exp_tog;
    logic [3:0]  exp_cs;
  } vec_t;

  vec_t tbl [7];
  int   b_pop, b_push, b_ovf, b_tog, b_cs, b_fall, b_long;
  logic [31:0] mask;

  task automatic snap();
    b_pop  = pop_cnt;
    b_push = push_cnt;
    b_ovf  = ovf_cnt;
    b_tog  = tog_cnt;
    b_cs   = cs_bad;
    b_fall = busy_fall;
  endtask

  task automatic cfg(input logic pol, input logic pha,
                     input logic [4:0] wl, input logic [3:0] ecs);
    cpol = pol;
    cpha = pha;
    word_len = wl;
    exp_cs = ecs;
    repeat (3) @(negedge clk);
    #1;
    snap();
  endtask

  initial begin
    tbl[0] = '{0,0,1,0,2'd0,4'hF,5'd7,32'hA5,32'hA5,32'hA5,16,4'hE};
    tbl[1] = '{1,1,1,1,2'd0,4'hF,5'd7,32'h3C,32'hC3,32'h3C,16,4'hE};
    tbl[2] = '{0,1,1,0,2'd3,4'hF,5'd15,32'h8001,32'h8001,
               32'h8001,32,4'h7};
    tbl[3] = '{1,0,1,1,2'd0,4'hF,5'd31,32'hDEADBEEF,32'h21524110,
               32'hDEADBEEF,64,4'hE};
    tbl[4] = '{0,0,0,0,2'd0,4'hB,5'd0,32'h1,32'h1,32'h1,2,4'hB};
    tbl[5] = '{0,0,1,1,2'd0,4'hF,5'd0,32'h0,32'h1,32'h0,2,4'hE};
    tbl[6] = '{0,1,1,0,2'd1,4'hF,5'd4,32'hFFFFFFF5,32'h15,
               32'h15,10,4'hD};

    reset = 1'b0; enable = 1'b0; word_len = 5'd7;
    cpol = 1'b0; cpha = 1'b0; cs_auto = 1'b1; cs_sel = 2'd0;
    cs_manual_n = 4'hF; tx_empty = 1'b1; tx_data = '0;
    rx_full = 1'b0; miso_inv = 1'b0;
    #23;
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_cs", 64'(cs_n), 64'hF);
    chk("rst_rx", 64'(rx_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mosi", 64'(mosi), 64'd0);
    reset = 1'b1;
    enable = 1'b1;
    b_long = long_cnt;

    for (int i = 0; i < 7; i++) begin
      cs_auto = tbl[i].auto_cs;
      cs_sel = tbl[i].sel;
      cs_manual_n = tbl[i].man;
      miso_inv = tbl[i].inv;
      cfg(tbl[i].cpol, tbl[i].cpha, tbl[i].wl, tbl[i].exp_cs);
      run(1, tbl[i].data, 32'h0);
      mask = 32'((33'h1 << (tbl[i].wl + 1)) - 33'h1);
      chk($sformatf("v%0d_rx", i), 64'(rx_data), 64'(tbl[i].exp_rx));
      chk($sformatf("v%0d_mosi", i), 64'(mosi_word[31:0] & mask),
          64'(tbl[i].exp_mosi));
      chk($sformatf("v%0d_tog", i), 64'(tog_cnt - b_tog),
          64'(tbl[i].exp_tog));
      chk($sformatf("v%0d_push", i), 64'(push_cnt - b_push), 64'd1);
      chk($sformatf("v%0d_pop", i), 64'(pop_cnt - b_pop), 64'd1);
      chk($sformatf("v%0d_cs", i), 64'(cs_bad - b_cs), 64'd0);
      chk($sformatf("v%0d_idle", i), 64'(sclk), 64'(tbl[i].cpol));
    end
    cs_auto = 1'b1;
    cs_sel = 2'd0;
    cs_manual_n = 4'hF;
    miso_inv = 1'b0;

    // Mode 3, two 32-bit words back to back
    cfg(1'b1, 1'b1, 5'd31, 4'hE);
    run(2, 32'hDEADBEEF, 32'h12345678);
    chk("b2b_pop", 64'(pop_cnt - b_pop), 64'd2);
    chk("b2b_push", 64'(push_cnt - b_push), 64'd2);
    chk("b2b_rx0", 64'(rx_log[b_push % 4]), 64'hDEADBEEF);
    chk("b2b_rx1", 64'(rx_log[(b_push + 1) % 4]), 64'h12345678);
    chk("b2b_mosi", mosi_word, 64'hDEADBEEF_12345678);
    chk("b2b_tog", 64'(tog_cnt - b_tog), 64'd128);
    chk("b2b_cs", 64'(cs_bad - b_cs), 64'd0);
    chk("b2b_gap", 64'(busy_fall - b_fall), 64'd1);
    chk("b2b_idle", 64'(sclk), 64'd1);

    // RX FIFO full at the end of the middle word
    cfg(1'b0, 1'b0, 5'd7, 4'hE);
    run(1, 32'h11, 32'h0);
    chk("ovf_pre_rx", 64'(rx_data), 64'h11);
    rx_full = 1'b1;
    snap();
    run(1, 32'h22, 32'h0);
    chk("ovf_cnt", 64'(ovf_cnt - b_ovf), 64'd1);
    chk("ovf_nopush", 64'(push_cnt - b_push), 64'd0);
    chk("ovf_rxkeep", 64'(rx_data), 64'h11);
    rx_full = 1'b0;
    snap();
    run(1, 32'h33, 32'h0);
    chk("ovf_next_rx", 64'(rx_data), 64'h33);
    chk("ovf_next_push", 64'(push_cnt - b_push), 64'd1);

    // Enable dropped after 5 toggles, mode 2
    cfg(1'b1, 1'b0, 5'd7, 4'hE);
    tx_data = 32'hFF;
    tx_empty = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 500 && !hit; c++) begin
        @(negedge clk);
        #1;
        if (tx_pop) tx_empty = 1'b1;
        if (tog_cnt - b_tog >= 5) hit = 1;
      end
      chk("abort_reach", 64'(hit), 64'd1);
    end
    tx_empty = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sclk", 64'(sclk), 64'd1);
    chk("abort_cs", 64'(cs_n), 64'hF);
    repeat (30) @(negedge clk);
    #1;
    chk("abort_push", 64'(push_cnt - b_push + ovf_cnt - b_ovf), 64'd0);
    enable = 1'b1;

    // Async reset between clock edges in mid-shift
    cfg(1'b1, 1'b1, 5'd31, 4'hE);
    tx_data = 32'hCAFEF00D;
    tx_empty = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int c = 0; c < 500 && !hit; c++) begin
        @(negedge clk);
        #1;
        if (tx_pop) tx_empty = 1'b1;
        if (tog_cnt - b_tog >= 3) hit = 1;
      end
      chk("rst_reach", 64'(hit), 64'd1);
    end
    tx_empty = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_cs", 64'(cs_n), 64'hF);
    chk("arst_sclk", 64'(sclk), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rx", 64'(rx_data), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cfg(1'b0, 1'b0, 5'd7, 4'hE);
    run(1, 32'hA5, 32'h0);
    chk("restart_rx", 64'(rx_data), 64'hA5);
    chk("restart_push", 64'(push_cnt - b_push), 64'd1);
    chk("strobe_width", 64'(long_cnt - b_long), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
